// File: rtl/spike_pushback_collector_pkg.sv
// Shared types and helpers for the spike pushback collector.
package spike_pushback_pkg;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} spk_coll_state_e;

   localparam int unsigned SPK_CNT_W = 16;

   function automatic logic [SPK_CNT_W-1:0] sat_inc(input logic [SPK_CNT_W-1:0] v);
      return (v == '1) ? v : v + SPK_CNT_W'(1);
   endfunction

endpackage

// File: rtl/spike_pushback_collector_fifo.sv
// Show-ahead event FIFO with synchronous flush; a push into a full FIFO
// is accepted when a pop frees the slot in the same cycle.
module spike_evt_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [AW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [AW-1:0] head_o,
   output logic          empty_o,
   output logic          full_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW-1:0] mem_q [DEPTH];
   logic          do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rptr_q[PW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + (PW+1)'(1);
         if (do_pop)  rptr_d = rptr_q + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wptr_q[PW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/spike_pushback_collector.sv
// Collects tinyODIN output spikes into a FIFO for the host reader, counts
// them per inference and signals completion once the FIFO has drained.
module spike_pushback_collector
   import spike_pushback_pkg::*;
#(
   parameter int unsigned N     = 256,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   spike_pushback_i,
   input  logic [$clog2(N)-1:0]   spike_pushback_addr_i,
   input  logic                   inference_done_i,
   output logic                   evt_valid_o,
   output logic [$clog2(N)-1:0]   evt_addr_o,
   input  logic                   evt_ready_i,
   output logic [SPK_CNT_W-1:0]   spike_count_o,
   output logic                   overflow_o,
   output logic                   done_o,
   output logic                   irq_o
);

   localparam int unsigned AW = $clog2(N);

   spk_coll_state_e      state_q, state_d;
   logic [SPK_CNT_W-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 irq_q, irq_d;
   logic                 fifo_empty, fifo_full;
   logic                 pop, push_req;

   assign pop      = !fifo_empty && evt_ready_i;
   assign push_req = spike_pushback_i && (state_q == RUN) && !clear_i;

   spike_evt_fifo #(
      .DEPTH(DEPTH),
      .AW   (AW)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (clear_i),
      .push_i     (push_req),
      .push_data_i(spike_pushback_addr_i),
      .pop_i      (pop),
      .head_o     (evt_addr_o),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      irq_d   = 1'b0;
      if (clear_i) begin
         state_d = RUN;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            RUN:     if (inference_done_i) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
         endcase
         // Dropped strobes still count; only acceptance depends on a same-cycle pop.
         if (push_req) begin
            cnt_d = sat_inc(cnt_q);
            if (fifo_full && !pop) ovf_d = 1'b1;
         end
         irq_d = (state_d == DONE) && (state_q != DONE);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         irq_q   <= irq_d;
      end
   end

   assign evt_valid_o   = !fifo_empty;
   assign spike_count_o = cnt_q;
   assign overflow_o    = ovf_q;
   assign done_o        = (state_q == DONE);
   assign irq_o         = irq_q;

endmodule

// File: tb/tb_spike_pushback_collector.sv
// Directed bench for spike_pushback_collector with a queue-based reference model.
module tb_spike_pushback_collector;

   localparam int N     = 256;
   localparam int DEPTH = 16;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          clear = 1'b0;
   logic          spike = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          inf_done = 1'b0;
   logic          ready = 1'b0;
   logic          evt_valid;
   logic [AW-1:0] evt_addr;
   logic [15:0]   spike_count;
   logic          overflow;
   logic          done;
   logic          irq;

   int checks = 0;
   int errors = 0;

   spike_pushback_collector #(
      .N    (N),
      .DEPTH(DEPTH)
   ) dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .clear_i              (clear),
      .spike_pushback_i     (spike),
      .spike_pushback_addr_i(addr),
      .inference_done_i     (inf_done),
      .evt_valid_o          (evt_valid),
      .evt_addr_o           (evt_addr),
      .evt_ready_i          (ready),
      .spike_count_o        (spike_count),
      .overflow_o           (overflow),
      .done_o               (done),
      .irq_o                (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy as a queue, inference phase as a plain label.
   localparam int P_RUN = 0, P_DRAIN = 1, P_DONE = 2;
   int q[$];
   int m_cnt = 0;
   bit m_ovf = 1'b0;
   bit m_irq = 1'b0;
   int m_phase = P_RUN;
   bit m_pop, m_push;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_cnt = 0; m_ovf = 0; m_irq = 0; m_phase = P_RUN;
      end else if (clear) begin
         q.delete();
         m_cnt = 0; m_ovf = 0; m_irq = 0; m_phase = P_RUN;
      end else begin
         m_pop  = (q.size() > 0) && ready;
         m_push = 0;
         m_irq  = 0;
         case (m_phase)
            P_RUN: begin
               if (spike) begin
                  if (m_cnt < 65535) m_cnt++;
                  if (q.size() < DEPTH || m_pop) m_push = 1;
                  else m_ovf = 1;
               end
               if (inf_done) m_phase = P_DRAIN;
            end
            P_DRAIN: if (q.size() == 0) begin
               m_phase = P_DONE;
               m_irq   = 1;
            end
            default: ;
         endcase
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(int'(addr));
      end
   end

   always @(negedge clk) begin
      check("valid", {31'd0, evt_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) check("addr", {24'd0, evt_addr}, q[0]);
      check("count", {16'd0, spike_count}, m_cnt);
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("done", {31'd0, done}, {31'd0, m_phase == P_DONE});
      check("irq", {31'd0, irq}, {31'd0, m_irq});
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int pops, last, first, n;

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("rst_valid", {31'd0, evt_valid}, 0);
      check("rst_count", {16'd0, spike_count}, 0);
      check("rst_done_irq", {30'd0, done, irq}, 0);
      #9 rst_n = 1'b1;
      cyc();

      // Basic stream
      ready = 1; spike = 1; addr = 8'd5;
      cyc(); check("basic_h0", {24'd0, evt_addr}, 5);
      addr = 8'd200;
      cyc(); check("basic_h1", {24'd0, evt_addr}, 200);
      addr = 8'd255;
      cyc(); check("basic_h2", {24'd0, evt_addr}, 255);
      spike = 0;
      check("basic_cnt", {16'd0, spike_count}, 3);
      cyc(); cyc();

      // Full FIFO with simultaneous push and pop
      clear = 1; cyc(); clear = 0;
      ready = 0;
      for (int i = 0; i < 16; i++) begin
         spike = 1; addr = AW'(10 + i); cyc();
      end
      spike = 0;
      check("full_ovf0", {31'd0, overflow}, 0);
      ready = 1; spike = 1; addr = 8'd99; cyc();
      spike = 0; ready = 0;
      check("pp_ovf", {31'd0, overflow}, 0);
      check("pp_cnt", {16'd0, spike_count}, 17);
      check("pp_head", {24'd0, evt_addr}, 11);
      ready = 1; pops = 0; last = 0;
      for (int i = 0; i < 40; i++) begin
         if (!evt_valid) break;
         last = int'(evt_addr); pops++; cyc();
      end
      check("pp_pops", pops, 16);
      check("pp_tail", last, 99);
      ready = 0;

      // Overflow
      clear = 1; cyc(); clear = 0;
      for (int i = 0; i < 18; i++) begin
         spike = 1; addr = AW'(30 + i); cyc();
         if (i == 15) check("ovf_before", {31'd0, overflow}, 0);
         if (i == 16) check("ovf_after17", {31'd0, overflow}, 1);
      end
      spike = 0;
      check("ovf_cnt", {16'd0, spike_count}, 18);
      ready = 1; pops = 0; last = 0; first = int'(evt_addr);
      for (int i = 0; i < 40; i++) begin
         if (!evt_valid) break;
         last = int'(evt_addr); pops++; cyc();
      end
      check("ovf_first", first, 30);
      check("ovf_pops", pops, 16);
      check("ovf_last", last, 45);
      ready = 0;

      // Done sequence
      clear = 1; cyc(); clear = 0;
      for (int i = 0; i < 4; i++) begin
         spike = 1; addr = AW'(50 + i); cyc();
      end
      spike = 0;
      inf_done = 1; cyc(); inf_done = 0;
      spike = 1; addr = 8'd7;
      for (int i = 0; i < 3; i++) begin
         cyc(); check("drain_done0", {31'd0, done}, 0);
      end
      ready = 1; n = 0;
      while (!done && n < 20) begin
         cyc(); n++;
      end
      check("done_latency", n, 5);
      check("done_irq", {31'd0, irq}, 1);
      cyc();
      check("done_irq_once", {31'd0, irq}, 0);
      check("done_hold", {31'd0, done}, 1);
      check("done_cnt", {16'd0, spike_count}, 4);
      check("done_valid", {31'd0, evt_valid}, 0);

      // Clear priority while in DONE
      clear = 1; spike = 1; addr = 8'd9; inf_done = 1; cyc();
      clear = 0; spike = 0; inf_done = 0;
      check("clr_valid", {31'd0, evt_valid}, 0);
      check("clr_cnt", {16'd0, spike_count}, 0);
      check("clr_flags", {29'd0, overflow, done, irq}, 0);
      ready = 0; spike = 1; addr = 8'd3; cyc(); spike = 0;
      check("clr_run_push", {23'd0, evt_valid, evt_addr}, {23'd0, 1'b1, 8'd3});

      // Asynchronous reset mid-stream
      for (int i = 0; i < 2; i++) begin
         spike = 1; addr = AW'(60 + i); cyc();
      end
      spike = 0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, evt_valid}, 0);
      check("arst_addr", {24'd0, evt_addr}, 0);
      check("arst_cnt", {16'd0, spike_count}, 0);
      check("arst_flags", {29'd0, overflow, done, irq}, 0);
      #4 rst_n = 1'b1;
      cyc(); cyc();
      check("post_rst_valid", {31'd0, evt_valid}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
